// File: rtl/sc_down_transition_timer_pkg.sv
// Shared definitions for the Frogger down-transition game timer.
//   state_e        : timer FSM state (2 bits)
//   DEF_*          : default data width, prescale and initial count
//   presc_width()  : bit width of a prescaler that counts 0..prescale-1
package sc_down_transition_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam int DEF_DATAWIDTH  = 8;
  localparam int DEF_PRESCALE   = 50000000;
  localparam int DEF_INIT_VALUE = 60;

  // $clog2 of 1 is 0; a register needs at least one bit.
  function automatic int presc_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/sc_down_transition_timer_if.sv
// Control/status bundle of the down-transition timer.
//   SC_DOWNTIMER_start_InLow      : start request, falling edge starts
//   SC_DOWNTIMER_pause_InLow      : level, low pauses while running
//   SC_DOWNTIMER_load_InLow       : level, low loads load_InBUS
//   SC_DOWNTIMER_load_InBUS       : value to load into the count
//   SC_DOWNTIMER_data_OutBUS      : current count (registered)
//   SC_DOWNTIMER_running_Out      : high in RUN
//   SC_DOWNTIMER_expired_Out      : high in EXPIRED
//   SC_DOWNTIMER_expiredPulse_Out : one cycle on entry to EXPIRED
//   SC_DOWNTIMER_state_Out        : FSM state for observation
// Handshake: there is no valid/ready pair; every input is a level sampled
// on each rising clock edge, and every output is valid for the whole cycle
// after the edge that produced it.
// master drives the controls (game logic / bench), slave is the timer.
interface sc_down_transition_timer_if #(
  parameter int DATAWIDTH = 8
);
  import sc_down_transition_timer_pkg::*;

  logic                 SC_DOWNTIMER_start_InLow;
  logic                 SC_DOWNTIMER_pause_InLow;
  logic                 SC_DOWNTIMER_load_InLow;
  logic [DATAWIDTH-1:0] SC_DOWNTIMER_load_InBUS;
  logic [DATAWIDTH-1:0] SC_DOWNTIMER_data_OutBUS;
  logic                 SC_DOWNTIMER_running_Out;
  logic                 SC_DOWNTIMER_expired_Out;
  logic                 SC_DOWNTIMER_expiredPulse_Out;
  state_e               SC_DOWNTIMER_state_Out;

  modport master (
    output SC_DOWNTIMER_start_InLow, SC_DOWNTIMER_pause_InLow,
           SC_DOWNTIMER_load_InLow, SC_DOWNTIMER_load_InBUS,
    input  SC_DOWNTIMER_data_OutBUS, SC_DOWNTIMER_running_Out,
           SC_DOWNTIMER_expired_Out, SC_DOWNTIMER_expiredPulse_Out,
           SC_DOWNTIMER_state_Out
  );

  modport slave (
    input  SC_DOWNTIMER_start_InLow, SC_DOWNTIMER_pause_InLow,
           SC_DOWNTIMER_load_InLow, SC_DOWNTIMER_load_InBUS,
    output SC_DOWNTIMER_data_OutBUS, SC_DOWNTIMER_running_Out,
           SC_DOWNTIMER_expired_Out, SC_DOWNTIMER_expiredPulse_Out,
           SC_DOWNTIMER_state_Out
  );

endinterface

// File: rtl/sc_tick_prescaler.sv
// Free-running prescaler that produces one decrement tick every PRESCALE
// enabled cycles.
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   enable : count this cycle (timer running, not paused/loading)
//   clear  : restart the prescale period from 0 (has priority)
//   tick   : high in the enabled cycle whose edge ends the period
module sc_tick_prescaler
  import sc_down_transition_timer_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            PW   = presc_width(PRESCALE);
  localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // Holding the count when disabled is what lets a pause resume mid-period.
  always_comb begin
    tick  = enable && (cnt_q == TERM);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sc_down_transition_timer.sv
// Loadable down-counting game timer. Counts the loaded value down by one per
// prescaled tick, stops at zero and reports expiry as a level and a
// one-cycle pulse. Started by a high-to-low transition on start_InLow.
//   SC_DOWNTIMER_CLOCK_50    : system clock, rising edge
//   SC_DOWNTIMER_RESET_InLow : synchronous active-low reset
//   bus_if                   : controls in, count/status out (slave side)
// Edge priority: reset > load > start event > pause > tick.
module sc_down_transition_timer
  import sc_down_transition_timer_pkg::*;
#(
  parameter int DOWNTIMER_DATAWIDTH  = DEF_DATAWIDTH,
  parameter int DOWNTIMER_PRESCALE   = DEF_PRESCALE,
  parameter int DOWNTIMER_INIT_VALUE = DEF_INIT_VALUE
) (
  input  logic                        SC_DOWNTIMER_CLOCK_50,
  input  logic                        SC_DOWNTIMER_RESET_InLow,
  sc_down_transition_timer_if.slave   bus_if
);

  localparam int                        DW     = DOWNTIMER_DATAWIDTH;
  localparam logic [DW-1:0]             INIT_V = DW'(DOWNTIMER_INIT_VALUE);
  localparam logic [DW-1:0]             ONE    = DW'(1);

  state_e        state_q, state_d;
  logic [DW-1:0] count_q, count_d;
  logic          pulse_q, pulse_d;
  logic          start_hist_q;

  logic          start_ev;
  logic          presc_en;
  logic          presc_clear;
  logic          tick;

  logic          load_n;
  logic          pause_n;
  logic          start_n;

  assign load_n  = bus_if.SC_DOWNTIMER_load_InLow;
  assign pause_n = bus_if.SC_DOWNTIMER_pause_InLow;
  assign start_n = bus_if.SC_DOWNTIMER_start_InLow;

  assign start_ev = start_hist_q && !start_n;

  // Kept outside the FSM process so tick (which depends on presc_en) does
  // not form a loop through a single combinational block.
  assign presc_en    = (state_q == ST_RUN) && load_n && pause_n;
  assign presc_clear = !load_n ||
                       (start_ev && ((state_q == ST_IDLE) || (state_q == ST_EXPIRED)));

  sc_tick_prescaler #(
    .PRESCALE (DOWNTIMER_PRESCALE)
  ) u_prescaler (
    .clk    (SC_DOWNTIMER_CLOCK_50),
    .rst_n  (SC_DOWNTIMER_RESET_InLow),
    .enable (presc_en),
    .clear  (presc_clear),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;
    if (!load_n) begin
      count_d = bus_if.SC_DOWNTIMER_load_InBUS;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_ev) begin
            if (count_q == '0) begin
              state_d = ST_EXPIRED;
              pulse_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!pause_n) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            // Zero is tested too so the count can never wrap below zero.
            if ((count_q == ONE) || (count_q == '0)) begin
              count_d = '0;
              state_d = ST_EXPIRED;
              pulse_d = 1'b1;
            end else begin
              count_d = count_q - ONE;
            end
          end
        end
        ST_PAUSE: begin
          if (pause_n) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          if (start_ev) begin
            count_d = INIT_V;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge SC_DOWNTIMER_CLOCK_50) begin
    if (!SC_DOWNTIMER_RESET_InLow) begin
      state_q      <= ST_IDLE;
      count_q      <= INIT_V;
      pulse_q      <= 1'b0;
      // Idles at 1 with start released; capturing the input instead of a
      // constant means a start held low through reset is not seen as an edge.
      start_hist_q <= start_n;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pulse_q      <= pulse_d;
      start_hist_q <= start_n;
    end
  end

  assign bus_if.SC_DOWNTIMER_data_OutBUS      = count_q;
  assign bus_if.SC_DOWNTIMER_running_Out      = (state_q == ST_RUN);
  assign bus_if.SC_DOWNTIMER_expired_Out      = (state_q == ST_EXPIRED);
  assign bus_if.SC_DOWNTIMER_expiredPulse_Out = pulse_q;
  assign bus_if.SC_DOWNTIMER_state_Out        = state_q;

endmodule
